// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared constants for the pwm_fade brightness-ramp sequencer.
//   - host register indices (decoded from addr[3:2])
//   - CTRL bit positions
//   - FSM state encoding (IDLE / RUN / WRITE)
//   - ramp direction encoding
//   - register reset values
package pwm_fade_pkg;

  // Host register map, indexed by addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STEP   = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_MAX    = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;  // no strobes issued
  localparam logic [1:0] ST_RUN   = 2'd1;  // prescaler counting
  localparam logic [1:0] ST_WRITE = 2'd2;  // strobe cycle

  // Ramp direction
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Register reset values; MAX resets to all ones of its width
  localparam logic [1:0]  CTRL_RST   = 2'b00;
  localparam int unsigned STEP_RST   = 32'd1;
  localparam int unsigned PERIOD_RST = 32'd0;

endpackage

// File: rtl/fade_tick.sv
// fade_tick: update-period prescaler for pwm_fade.
//   clk     in   system clock
//   resetn  in   asynchronous active-low reset
//   period  in   tick fires when the count reaches (or exceeds) this value
//   enable  in   counter runs while high, held at 0 while low
//   clear   in   synchronous clear of the count
//   tick    out  one-cycle pulse; spacing is period+1 cycles
module fade_tick
  import pwm_fade_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  enable,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;
  logic                  reached_s;

  // ">=" rather than "==" so a period lowered below the count fires at once
  // instead of wrapping the counter.
  assign reached_s = (cnt_q >= period);
  assign tick      = enable & ~clear & reached_s;

  // Next count: clear on request or when idle, restart after a tick
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (reached_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_fade.sv
// pwm_fade: programmable brightness-ramp sequencer feeding the PWM driver.
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   sel        in   host select
//   wstrb      in   host write strobe (write = sel & wstrb)
//   addr       in   host byte address, addr[3:2] decoded
//   wdata      in   host write data
//   rdata      out  combinational register readback on addr
//   pwm_sel    out  PWM driver select (one cycle per level update)
//   pwm_wstrb  out  PWM driver write strobe (same cycle as pwm_sel)
//   pwm_wdata  out  zero-extended duty level
module pwm_fade
  import pwm_fade_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        pwm_sel,
  output logic        pwm_wstrb,
  output logic [31:0] pwm_wdata
);

  // Register file
  logic [1:0]            ctrl_q,   ctrl_d;
  logic [WIDTH-1:0]      step_q,   step_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [WIDTH-1:0]      max_q,    max_d;

  // Sequencer state
  logic [1:0]            state_q,  state_d;
  logic [WIDTH-1:0]      level_q,  level_d;
  logic                  dir_q,    dir_d;
  logic                  sel_q,    wstrb_q;
  logic                  strobe_d;
  logic [31:0]           pwm_wdata_q, pwm_wdata_d;

  logic                  host_wr_s;
  logic                  wr_ctrl_s;
  logic                  tick_s;
  logic                  run_en_s;
  logic [WIDTH:0]        sum_s;
  logic [WIDTH-1:0]      next_level_s;
  logic                  next_dir_s;
  logic                  unused_bits_s;

  assign host_wr_s = sel & wstrb;
  assign wr_ctrl_s = host_wr_s & (addr[3:2] == REG_CTRL);
  assign run_en_s  = (state_q != ST_IDLE);

  // Byte-lane bits and wide data bits that no register stores
  assign unused_bits_s = ^{addr[1:0], wdata};

  fade_tick #(
    .PRESCALE_W (PRESCALE_W)
  ) u_fade_tick (
    .clk    (clk),
    .resetn (resetn),
    .period (period_q),
    .enable (run_en_s),
    .clear  (wr_ctrl_s),
    .tick   (tick_s)
  );

  // Host register writes
  always_comb begin
    ctrl_d   = ctrl_q;
    step_d   = step_q;
    period_d = period_q;
    max_d    = max_q;
    if (host_wr_s) begin
      case (addr[3:2])
        REG_CTRL:   ctrl_d   = wdata[CTRL_MODE_BIT:CTRL_EN_BIT];
        REG_STEP:   step_d   = wdata[WIDTH-1:0];
        REG_PERIOD: period_d = wdata[PRESCALE_W-1:0];
        REG_MAX:    max_d    = wdata[WIDTH-1:0];
        default:    ctrl_d   = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Register readback, zero-extended
  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      REG_CTRL:   rdata = 32'(ctrl_q);
      REG_STEP:   rdata = 32'(step_q);
      REG_PERIOD: rdata = 32'(period_q);
      REG_MAX:    rdata = 32'(max_q);
      default:    rdata = 32'd0;
    endcase
  end

  // Next level/direction. The sum is one bit wider so level+STEP never wraps.
  // Sawtooth reuses the down direction as "at the top": the step after
  // reaching MAX drops to 0, so MAX itself is always emitted once.
  always_comb begin
    sum_s        = {1'b0, level_q} + {1'b0, step_q};
    next_level_s = level_q;
    next_dir_s   = dir_q;
    if (dir_q == DIR_UP) begin
      if (sum_s >= {1'b0, max_q}) begin
        next_level_s = max_q;
        next_dir_s   = DIR_DOWN;
      end else begin
        next_level_s = sum_s[WIDTH-1:0];
        next_dir_s   = DIR_UP;
      end
    end else if (ctrl_q[CTRL_MODE_BIT]) begin
      next_level_s = '0;
      next_dir_s   = DIR_UP;
    end else if (level_q < step_q) begin
      next_level_s = '0;
      next_dir_s   = DIR_UP;
    end else begin
      next_level_s = level_q - step_q;
      next_dir_s   = DIR_DOWN;
    end
  end

  // Sequencer FSM. A CTRL write overrides any tick in the same cycle.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    dir_d       = dir_q;
    strobe_d    = 1'b0;
    pwm_wdata_d = pwm_wdata_q;
    if (wr_ctrl_s) begin
      if (wdata[CTRL_EN_BIT]) begin
        // (Re)start: emit level 0 immediately
        state_d     = ST_WRITE;
        level_d     = '0;
        dir_d       = DIR_UP;
        strobe_d    = 1'b1;
        pwm_wdata_d = 32'd0;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN, ST_WRITE: begin
          // The strobe cycle also counts toward the period, which keeps
          // strobes PERIOD+1 apart (and back-to-back when PERIOD is 0).
          if (tick_s) begin
            state_d     = ST_WRITE;
            level_d     = next_level_s;
            dir_d       = next_dir_s;
            strobe_d    = 1'b1;
            pwm_wdata_d = 32'(next_level_s);
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Host register file flops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q   <= CTRL_RST;
      step_q   <= WIDTH'(STEP_RST);
      period_q <= PRESCALE_W'(PERIOD_RST);
      max_q    <= '1;
    end else begin
      ctrl_q   <= ctrl_d;
      step_q   <= step_d;
      period_q <= period_d;
      max_q    <= max_d;
    end
  end

  // Sequencer state and registered driver outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      dir_q       <= DIR_UP;
      sel_q       <= 1'b0;
      wstrb_q     <= 1'b0;
      pwm_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      dir_q       <= dir_d;
      sel_q       <= strobe_d;
      wstrb_q     <= strobe_d;
      pwm_wdata_q <= pwm_wdata_d;
    end
  end

  assign pwm_sel   = sel_q;
  assign pwm_wstrb = wstrb_q;
  assign pwm_wdata = pwm_wdata_q;

endmodule

// File: tb/tb_pwm_fade.sv
// tb_pwm_fade: self-checking bench for pwm_fade. Strobes are captured by a
// monitor (edge index + value) and compared with a level sequence computed
// from the ramp rules in plain integer arithmetic.
module tb_pwm_fade;

  logic        clk;
  logic        resetn;
  logic        sel;
  logic        wstrb;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        pwm_sel;
  logic        pwm_wstrb;
  logic [31:0] pwm_wdata;

  int n_checks;
  int n_errors;
  int edge_cnt;
  int last_wr_edge;
  int sq_val[$];
  int sq_cyc[$];

  pwm_fade #(
    .WIDTH      (12),
    .PRESCALE_W (16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sel       (sel),
    .wstrb     (wstrb),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .pwm_sel   (pwm_sel),
    .pwm_wstrb (pwm_wstrb),
    .pwm_wdata (pwm_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: count edges, record every strobe, sel must track wstrb
  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    #1;
    check("sel_eq_wstrb", {31'd0, pwm_sel}, {31'd0, pwm_wstrb});
    if (pwm_wstrb === 1'b1) begin
      sq_val.push_back(int'(pwm_wdata));
      sq_cyc.push_back(edge_cnt);
    end
  end

  // Called just after a negedge; the write is sampled at the next posedge
  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    sel          = 1'b1;
    wstrb        = 1'b1;
    addr         = a;
    wdata        = d;
    last_wr_edge = edge_cnt + 1;
    @(negedge clk);
    sel   = 1'b0;
    wstrb = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  // Ramp rules: up clamps at MAX (then down / wrap), down floors at 0
  task automatic model_step(input int mx, input int st, input int saw,
                            inout int lvl, inout int up);
    if (up != 0) begin
      if (lvl + st >= mx) begin lvl = mx; up = 0; end
      else lvl = lvl + st;
    end else if (saw != 0) begin
      lvl = 0; up = 1;
    end else if (lvl < st) begin
      lvl = 0; up = 1;
    end else begin
      lvl = lvl - st;
    end
  endtask

  task automatic run_ramp(input int mx, input int st, input int pd, input int saw, input int n);
    int lvl, up, e, waited, got_n;
    host_write(4'hC, 32'(mx));
    host_write(4'h4, 32'(st));
    host_write(4'h8, 32'(pd));
    sq_val.delete();
    sq_cyc.delete();
    host_write(4'h0, 32'(1 + 2 * saw));
    e = last_wr_edge;
    waited = 0;
    while (sq_val.size() < n && waited < n * (pd + 1) + 20) begin
      @(negedge clk);
      waited++;
    end
    host_write(4'h0, 32'd0);
    got_n = (sq_val.size() >= n) ? n : sq_val.size();
    check("ramp_count", 32'(got_n), 32'(n));
    lvl = 0;
    up  = 1;
    for (int i = 0; i < got_n; i++) begin
      check("ramp_val", 32'(sq_val[i]), 32'(lvl));
      check("ramp_gap", 32'(sq_cyc[i] - e), 32'(i * (pd + 1)));
      model_step(mx, st, saw, lvl, up);
    end
  endtask

  initial begin
    int tri_exp[8];
    int saw_exp[6];
    int e, n;
    tri_exp = '{0, 4, 8, 10, 6, 2, 0, 4};
    saw_exp = '{0, 4, 8, 10, 0, 4};
    n_checks = 0;
    n_errors = 0;
    edge_cnt = 0;
    resetn = 1'b0;
    sel    = 1'b0;
    wstrb  = 1'b0;
    addr   = 4'h0;
    wdata  = 32'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    check("rst_sel",   {31'd0, pwm_sel},   32'd0);
    check("rst_wstrb", {31'd0, pwm_wstrb}, 32'd0);
    check("rst_wdata", pwm_wdata, 32'd0);
    read_check("rst_ctrl",   4'h0, 32'd0);
    read_check("rst_step",   4'h4, 32'd1);
    read_check("rst_period", 4'h8, 32'd0);
    read_check("rst_max",    4'hC, 32'h0000_0FFF);
    @(negedge clk);

    // Triangle and sawtooth from the test plan
    run_ramp(10, 4, 2, 0, 8);
    for (int i = 0; i < 8 && i < sq_val.size(); i++)
      check("tri_seq", 32'(sq_val[i]), 32'(tri_exp[i]));
    run_ramp(10, 4, 2, 1, 6);
    for (int i = 0; i < 6 && i < sq_val.size(); i++)
      check("saw_seq", 32'(sq_val[i]), 32'(saw_exp[i]));

    // STEP=0, PERIOD=0, MAX=0
    run_ramp(10, 0, 3, 0, 5);
    run_ramp(100, 7, 0, 0, 20);
    run_ramp(0, 5, 1, 1, 6);

    // Randomized ramps
    for (int k = 0; k < 8; k++)
      run_ramp(int'($urandom_range(0, 40)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 1)), 12);

    // PERIOD lowered from 100 to 5 while cnt=50
    host_write(4'hC, 32'h0000_0FFF);
    host_write(4'h4, 32'd1);
    host_write(4'h8, 32'd100);
    sq_val.delete();
    sq_cyc.delete();
    host_write(4'h0, 32'd1);
    e = last_wr_edge;
    while (edge_cnt < e + 50) @(negedge clk);
    host_write(4'h8, 32'd5);
    repeat (10) @(negedge clk);
    host_write(4'h0, 32'd0);
    check("plow_count", 32'(sq_val.size() >= 3), 32'd1);
    if (sq_val.size() >= 3) begin
      check("plow_gap1", 32'(sq_cyc[1] - e), 32'd52);
      check("plow_val1", 32'(sq_val[1]), 32'd1);
      check("plow_gap2", 32'(sq_cyc[2] - e), 32'd58);
    end

    // Disable during a strobe at level 8, then restart
    host_write(4'hC, 32'd10);
    host_write(4'h4, 32'd4);
    host_write(4'h8, 32'd2);
    sq_val.delete();
    sq_cyc.delete();
    host_write(4'h0, 32'd1);
    for (int w = 0; w < 40 && sq_val.size() < 3; w++) @(negedge clk);
    check("dis_reach", 32'(sq_val.size()), 32'd3);
    if (sq_val.size() >= 3) check("dis_lvl8", 32'(sq_val[2]), 32'd8);
    check("dis_in_strobe", {31'd0, pwm_wstrb}, 32'd1);
    host_write(4'h0, 32'd0);
    check("dis_drop", {31'd0, pwm_wstrb}, 32'd0);
    n = sq_val.size();
    repeat (20) @(negedge clk);
    check("dis_quiet", 32'(sq_val.size()), 32'(n));
    host_write(4'h0, 32'd1);
    check("restart_wstrb", {31'd0, pwm_wstrb}, 32'd1);
    check("restart_wdata", pwm_wdata, 32'd0);
    check("restart_edge", 32'(sq_cyc[sq_cyc.size() - 1]), 32'(last_wr_edge));
    host_write(4'h0, 32'd0);

    // Readback and ignored writes
    host_write(4'h4, 32'hFFFF_F123);
    read_check("step_rb", 4'h4, 32'h0000_0123);
    host_write(4'hC, 32'h0000_07FF);
    @(negedge clk);
    sel = 1'b0; wstrb = 1'b1; addr = 4'hC; wdata = 32'd0;
    @(negedge clk);
    addr = 4'h0; wdata = 32'd1;
    sq_val.delete();
    sq_cyc.delete();
    @(negedge clk);
    wstrb = 1'b0;
    repeat (10) @(negedge clk);
    read_check("nosel_max", 4'hC, 32'h0000_07FF);
    read_check("nosel_ctrl", 4'h0, 32'd0);
    check("nosel_nostrobe", 32'(sq_val.size()), 32'd0);
    @(negedge clk);

    // Asynchronous reset mid-run
    host_write(4'h4, 32'd3);
    host_write(4'h8, 32'd0);
    host_write(4'h0, 32'd3);
    repeat (5) @(negedge clk);
    check("pre_rst_wstrb", {31'd0, pwm_wstrb}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_sel",   {31'd0, pwm_sel},   32'd0);
    check("arst_wstrb", {31'd0, pwm_wstrb}, 32'd0);
    check("arst_wdata", pwm_wdata, 32'd0);
    read_check("arst_ctrl", 4'h0, 32'd0);
    read_check("arst_step", 4'h4, 32'd1);
    read_check("arst_max",  4'hC, 32'h0000_0FFF);
    @(negedge clk);
    resetn = 1'b1;
    sq_val.delete();
    sq_cyc.delete();
    repeat (20) @(negedge clk);
    check("post_rst_quiet", 32'(sq_val.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_fade.md
# pwm_fade

Programmable brightness-ramp sequencer that feeds the PWM LED driver stage. It holds a small host-writable register set, steps a duty-cycle level up/down (triangle) or up-and-wrap (sawtooth) at a programmable rate, and issues one write strobe per level update on the PWM driver's sel/wstrb/wdata port. It sits between the host bus decoder and the PWM driver.

## Interface
- WIDTH, 12: duty-cycle width; must equal the PWM driver's WIDTH
- PRESCALE_W, 16: width of the update-period counter
- clk  in  1  system clock; one clock, all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- sel  in  1  host select; accesses are ignored while low
- wstrb  in  1  host write strobe
- addr  in  4  host byte address; only addr[3:2] is decoded
- wdata  in  32  host write data
- rdata  out  32  register readback, combinational on addr
- pwm_sel  out  1  select to PWM driver
- pwm_wstrb  out  1  write strobe to PWM driver
- pwm_wdata  out  32  duty value to PWM driver; zero-extended level

## Operation
- Registers, selected by addr[3:2]:
  - 0 = CTRL: bit0 enable, bit1 mode (0 triangle, 1 sawtooth)
  - 1 = STEP: WIDTH bits
  - 2 = PERIOD: PRESCALE_W bits
  - 3 = MAX: WIDTH bits
- Register reset values: CTRL=0, STEP=1, PERIOD=0, MAX=all ones.
- A host write occurs when sel & wstrb. Reads return the register value, zero-extended; unused bits read 0.
- States:
  - IDLE: no strobes issued.
  - RUN: prescaler counts.
  - WRITE: strobe cycle.
- State transitions:
  - IDLE -> WRITE on a CTRL write with enable=1. level is cleared to 0 and dir is set to up.
  - WRITE -> RUN after 1 cycle.
  - RUN -> WRITE when cnt >= PERIOD. cnt clears to 0 and level updates in the same edge. Otherwise cnt increments.
  - Any state -> IDLE on a CTRL write with enable=0.
- Level update, performed in WIDTH+1-bit arithmetic with no wrap of the sum:
  - Up: if level+STEP >= MAX, then level = MAX. In triangle mode dir becomes down; in sawtooth mode level = 0 instead.
  - Down: if level < STEP, then level = 0 and dir becomes up; otherwise level = level - STEP.
- Boundary conditions:
  - STEP=0: level holds; strobes continue every PERIOD+1 cycles.
  - MAX=0: level stays 0.
  - level > MAX after MAX is lowered: the next up-step clamps to MAX. A down-step proceeds normally.
  - STEP, PERIOD or MAX written while running: takes effect at the next tick. cnt is not reset.
  - PERIOD written below the current cnt: a tick fires on the next cycle, with no counter wrap.
  - CTRL enable=1 written while already running: restarts the ramp from level 0, dir up.
  - A host write in the same cycle as a tick: the register update and the tick both take effect. The tick uses the old register values.
- Reset mid-operation: all state returns to reset values immediately, asynchronously.

## Timing
- Outputs are registered except rdata.
- Reset values: pwm_sel=0, pwm_wstrb=0, pwm_wdata=0, state IDLE, cnt=0, level=0, dir=up.
- pwm_sel and pwm_wstrb are both high for exactly one cycle per update, and pwm_wdata is valid in that same cycle.
- Enable write sampled at edge N: strobe high during cycle N+1 with pwm_wdata=0.
- Steady state: strobes are spaced PERIOD+1 cycles apart; PERIOD=0 gives a strobe every cycle.
- A disable write during the strobe cycle: the strobe drops at the next edge and no further strobes are issued.

## Structure
- Package pwm_fade_pkg holds:
  - the register index constants (CTRL, STEP, PERIOD, MAX)
  - the CTRL bit positions
  - the state enum {IDLE, RUN, WRITE}
  - the reset values of the registers
- One sub-module, fade_tick: the prescaler counter. Inputs are period, enable, and a clear; output is a one-cycle tick.
- Level/direction arithmetic and the register file live in pwm_fade.

## Test plan
- Reset: hold resetn low mid-run -> all outputs 0 immediately; after release, no strobes until enable.
- Triangle: MAX=10, STEP=4, PERIOD=2, enable -> strobes every 3 cycles carrying 0, 4, 8, 10, 6, 2, 0, 4.
- Sawtooth: MAX=10, STEP=4, mode=1 -> strobes carry 0, 4, 8, 10, 0, 4.
- Edge cases:
  - STEP=0 -> every strobe carries 0.
  - PERIOD=0 -> pwm_wstrb is high every cycle after the first strobe.
  - PERIOD lowered from 100 to 5 while cnt=50 -> the next tick fires in the following cycle.
- Disable/restart: enable, wait until level=8, write CTRL=0 -> no further strobes; write CTRL=1 -> next cycle strobe with pwm_wdata=0.
- Readback: write STEP=0x123 with wdata upper bits set -> rdata at addr 4 reads 0x00000123. A write with sel=0 changes nothing.
